// File: rtl/dma_copy_master.sv
// Word-by-word memory copy engine: reads src+i, writes dst+i for i in [0, len).
// Stalls while grant is low; aborts with a sticky err on an inaccessible address.
module dma_copy_master #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] xfer_cnt,
  input  logic             grant,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_accessable
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             err_q, err_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      data_q  <= 32'd0;
      len_q   <= {LEN_W{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a low grant leaves every register untouched
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cnt_inc = cnt_q + LEN_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          len_d   = len;
          cnt_d   = {LEN_W{1'b0}};
          err_d   = 1'b0;
          state_d = (len == {LEN_W{1'b0}}) ? FIN : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (grant && mem_accessable) begin
          data_d  = mem_rdata;
          state_d = WRITE;
        end else if (grant) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (grant && mem_accessable) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? FIN : READ;
        end else if (grant) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = WRITE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decoded from the registered state; address offset wraps modulo 2^32
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_q)
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = src_q + 32'(cnt_q);
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_q + 32'(cnt_q);
        mem_wdata = data_q;
      end
      default: begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
      end
    endcase
  end

  assign err      = err_q;
  assign xfer_cnt = cnt_q;

endmodule
